// File: rtl/domain_reg_arbiter_pkg.sv
// Shared definitions for the two-domain register-bank arbiter: FSM encodings,
// domain identifiers and the round-robin target selection.
package domain_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_SCRUB = 2'd2
  } arb_state_e;

  localparam logic DOM_NORMAL = 1'b0;
  localparam logic DOM_SECURE = 1'b1;

  // When both domains request, the one that did not hold the bank last wins.
  function automatic logic rr_target(input logic [1:0] val, input logic last);
    if (val == 2'b11) return ~last;
    return val[DOM_SECURE] ? DOM_SECURE : DOM_NORMAL;
  endfunction

  function automatic logic [1:0] dom_onehot(input logic dom);
    return dom ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/domain_reg_arbiter_bank.sv
// Shared register bank: one write port, one scrub-clear port (clear wins),
// registered read port. Contents are cleared by the asynchronous reset.
module domain_reg_bank #(
  parameter int p_nbits = 32,
  parameter int p_nregs = 4,
  parameter int p_aw    = $clog2(p_nregs)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [p_aw-1:0]    waddr,
  input  logic [p_nbits-1:0] wdata,
  input  logic               clr,
  input  logic [p_aw-1:0]    caddr,
  input  logic               ren,
  input  logic [p_aw-1:0]    raddr,
  output logic [p_nbits-1:0] rdata
);

  logic [p_nbits-1:0] mem [p_nregs];
  logic               rd_ok;

  generate
    if (p_nregs == (1 << p_aw)) begin : g_full
      assign rd_ok = 1'b1;
    end else begin : g_partial
      assign rd_ok = int'(raddr) < p_nregs;
    end
  endgenerate

  // NOTE: the bank is built from flops rather than a RAM macro because every
  // entry must clear on the asynchronous reset so no data survives into the
  // next owner's session; a RAM array cannot be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < p_nregs; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, so the read below sees the old contents.
      for (int i = 0; i < p_nregs; i++) begin
        if (clr && caddr == p_aw'(i))      mem[i] <= '0;
        else if (wen && waddr == p_aw'(i)) mem[i] <= wdata;
      end
      // Idle read data is forced to zero so stale contents never linger.
      rdata <= (ren && rd_ok) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/domain_reg_arbiter.sv
// Grants a shared register bank to a normal and a secure domain in turn,
// scrubbing every entry before ownership changes hands.
module domain_reg_arbiter
  import domain_reg_arbiter_pkg::*;
#(
  parameter  int p_nbits    = 32,
  parameter  int p_nregs    = 4,
  parameter  int p_hold_max = 8,
  localparam int AW         = $clog2(p_nregs)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_val,
  input  logic               req0_wen,
  input  logic [AW-1:0]      req0_addr,
  input  logic [p_nbits-1:0] req0_wdata,
  output logic               req0_rdy,
  input  logic               req1_val,
  input  logic               req1_wen,
  input  logic [AW-1:0]      req1_addr,
  input  logic [p_nbits-1:0] req1_wdata,
  output logic               req1_rdy,
  output logic               resp_val,
  output logic [p_nbits-1:0] resp_rdata,
  output logic               owner,
  output logic               scrubbing
);

  localparam int              HW        = $clog2(p_hold_max + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(p_hold_max);
  localparam logic [AW-1:0]   SIDX_LAST = AW'(p_nregs - 1);

  arb_state_e         state;
  logic               last;
  logic [HW-1:0]      hold;
  logic [AW-1:0]      sidx;
  logic [1:0]         rdy;

  logic [1:0]         val;
  logic               own_val;
  logic               oth_val;
  logic               own_wen;
  logic [AW-1:0]      own_addr;
  logic [p_nbits-1:0] own_wdata;
  logic               acc;
  logic [HW-1:0]      hold_inc;
  logic               exit_grant;
  logic               tgt;

  assign val = {req1_val, req0_val};

  // NOTE: every output of this block gets a value on every path, so no
  // latches are inferred.
  always_comb begin
    own_val    = val[owner];
    oth_val    = val[~owner];
    own_wen    = owner ? req1_wen   : req0_wen;
    own_addr   = owner ? req1_addr  : req0_addr;
    own_wdata  = owner ? req1_wdata : req0_wdata;
    acc        = rdy[owner] & own_val;
    hold_inc   = (acc && hold != HOLD_MAX) ? hold + 1'b1 : hold;
    // The hold limit counts the transaction accepted at this very edge, so
    // the grant ends right after the last permitted one.
    exit_grant = !own_val || (hold_inc == HOLD_MAX && oth_val);
    tgt        = rr_target(val, last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      owner     <= DOM_NORMAL;
      last      <= DOM_NORMAL;
      hold      <= '0;
      sidx      <= '0;
      rdy       <= '0;
      resp_val  <= 1'b0;
      scrubbing <= 1'b0;
    end else begin
      resp_val <= acc & ~own_wen;
      case (state)
        ARB_IDLE: begin
          if (|val) begin
            if (tgt == owner) begin
              state <= ARB_GRANT;
              hold  <= '0;
              rdy   <= dom_onehot(owner);
            end else begin
              state     <= ARB_SCRUB;
              sidx      <= '0;
              scrubbing <= 1'b1;
            end
          end
        end
        ARB_GRANT: begin
          hold <= hold_inc;
          if (exit_grant) begin
            last <= owner;
            rdy  <= '0;
            if (oth_val) begin
              state     <= ARB_SCRUB;
              sidx      <= '0;
              scrubbing <= 1'b1;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        ARB_SCRUB: begin
          if (sidx == SIDX_LAST) begin
            // Ownership flips only here, once every entry has been zeroed.
            owner     <= ~owner;
            sidx      <= '0;
            hold      <= '0;
            scrubbing <= 1'b0;
            if (oth_val) begin
              state <= ARB_GRANT;
              rdy   <= dom_onehot(~owner);
            end else begin
              state <= ARB_IDLE;
            end
          end else begin
            sidx <= sidx + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign req0_rdy = rdy[DOM_NORMAL];
  assign req1_rdy = rdy[DOM_SECURE];

  domain_reg_bank #(
    .p_nbits(p_nbits),
    .p_nregs(p_nregs),
    .p_aw   (AW)
  ) u_bank (
    .clk  (clk),
    .rst_n(reset),
    .wen  (acc & own_wen),
    .waddr(own_addr),
    .wdata(own_wdata),
    .clr  (state == ARB_SCRUB),
    .caddr(sidx),
    .ren  (acc & ~own_wen),
    .raddr(own_addr),
    .rdata(resp_rdata)
  );

endmodule

// File: tb/tb_domain_reg_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level model of ownership, scrubbing and bank contents.
module tb_domain_reg_arbiter;

  localparam int NREGS = 4;
  localparam int HOLD  = 8;

  logic        clk;
  logic        reset;
  logic        req0_val, req0_wen, req1_val, req1_wen;
  logic [1:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_rdy, req1_rdy, resp_val, owner, scrubbing;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_owner, m_last, m_count, m_scrub_left;
  bit          m_granted, m_resp_val;
  logic [31:0] m_resp_rdata;
  logic [31:0] m_bank [NREGS];

  domain_reg_arbiter #(.p_nbits(32), .p_nregs(NREGS), .p_hold_max(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req0_wen  (req0_wen),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .req0_rdy  (req0_rdy),
    .req1_val  (req1_val),
    .req1_wen  (req1_wen),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .req1_rdy  (req1_rdy),
    .resp_val  (resp_val),
    .resp_rdata(resp_rdata),
    .owner     (owner),
    .scrubbing (scrubbing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 0; m_count = 0; m_scrub_left = 0;
    m_granted = 0; m_resp_val = 0; m_resp_rdata = '0;
    for (int i = 0; i < NREGS; i++) m_bank[i] = '0;
  endtask

  // One clock edge of the arbitration rules, applied to the current inputs.
  task automatic model_edge();
    logic [1:0]  v;
    int          own, oth, a, tgt;
    bit          acc, w;
    logic [31:0] d;
    v   = {req1_val, req0_val};
    own = m_owner;
    oth = 1 - own;
    acc = m_granted && v[own];
    w   = (own == 1) ? req1_wen : req0_wen;
    a   = (own == 1) ? int'(req1_addr) : int'(req0_addr);
    d   = (own == 1) ? req1_wdata : req0_wdata;
    m_resp_val   = acc && !w;
    m_resp_rdata = (acc && !w && a < NREGS) ? m_bank[a] : '0;
    if (acc && w && a < NREGS) m_bank[a] = d;
    if (m_scrub_left > 0) begin
      m_bank[NREGS - m_scrub_left] = '0;
      m_scrub_left--;
      if (m_scrub_left == 0) begin
        m_owner = oth;
        if (v[oth]) begin m_granted = 1; m_count = 0; end
      end
    end else if (m_granted) begin
      if (acc && m_count < HOLD) m_count++;
      if (!v[own] || (m_count == HOLD && v[oth])) begin
        m_last    = own;
        m_granted = 0;
        if (v[oth]) m_scrub_left = NREGS;
      end
    end else if (v != 2'b00) begin
      tgt = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
      if (tgt == own) begin m_granted = 1; m_count = 0; end
      else m_scrub_left = NREGS;
    end
  endtask

  task automatic compare_all();
    check("rdy0",       req0_rdy,   m_granted && m_owner == 0);
    check("rdy1",       req1_rdy,   m_granted && m_owner == 1);
    check("resp_val",   resp_val,   m_resp_val);
    check("resp_rdata", resp_rdata, m_resp_rdata);
    check("owner",      owner,      m_owner);
    check("scrubbing",  scrubbing,  m_scrub_left > 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive0(input logic v, input logic w, input logic [1:0] a, input logic [31:0] d);
    req0_val = v; req0_wen = w; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic w, input logic [1:0] a, input logic [31:0] d);
    req1_val = v; req1_wen = w; req1_addr = a; req1_wdata = d;
  endtask

  task automatic wait_rdy(input int dom, input string tag);
    for (int i = 0; i < 40; i++) begin
      if ((dom == 0) ? req0_rdy : req1_rdy) break;
      step();
    end
    check(tag, (dom == 0) ? req0_rdy : req1_rdy, 1);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check({tag, "_owner"}, owner, 0);
    check({tag, "_scrub"}, scrubbing, 0);
    check({tag, "_rdy"},   {req1_rdy, req0_rdy}, 0);
  endtask

  int cur_dom, cur_len, gap, sc;
  int run_dom[$];
  int run_len[$];
  int gaps[$];

  task automatic record(input int d);
    if (d != cur_dom) begin
      if (cur_dom >= 0) begin
        run_dom.push_back(cur_dom);
        run_len.push_back(cur_len);
        gaps.push_back(gap);
      end
      cur_dom = d; cur_len = 1; gap = 0;
    end else begin
      cur_len++;
    end
  endtask

  initial begin
    // 1: reset held three cycles with domain 0 already requesting
    reset = 1'b0;
    drive0(1, 0, 0, '0);
    drive1(0, 0, 0, '0);
    model_reset();
    repeat (3) step();
    check("t1_owner_rst", owner, 0);
    reset = 1'b1;
    check("t1_rdy0_pre", req0_rdy, 0);
    step();
    check("t1_rdy0", req0_rdy, 1);
    check("t1_noscrub", scrubbing, 0);

    // 2: domain 0 writes, domain 1 takes over after a full scrub
    drive0(1, 1, 2, 32'hDEADBEEF);
    step();
    drive0(0, 0, 0, '0);
    drive1(1, 0, 2, '0);
    sc = 0;
    for (int i = 0; i < 20 && !req1_rdy; i++) begin
      step();
      if (scrubbing) sc++;
    end
    check("t2_scrub_cycles", sc, 4);
    check("t2_rdy1", req1_rdy, 1);
    check("t2_owner", owner, 1);
    step();
    check("t2_resp_val", resp_val, 1);
    check("t2_rdata", resp_rdata, 32'h0);

    // 3: both domains stream; grants alternate with a fixed hold length
    cur_dom = -1; cur_len = 0; gap = 0;
    for (int i = 0; i < 70; i++) begin
      drive0(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      drive1(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      if (req0_rdy) record(0);
      if (req1_rdy) record(1);
      if (scrubbing) gap++;
      step();
    end
    check("t3_runs", run_len.size() >= 5, 1);
    for (int k = 1; k <= 4; k++) begin
      check("t3_len", run_len[k], HOLD);
      check("t3_dom", run_dom[k], (k % 2 == 1) ? 0 : 1);
      check("t3_gap", gaps[k-1], NREGS);
    end

    // 4a: owner=0 with last=1 -> simultaneous requests grant domain 0 at once
    drive0(0, 0, 0, '0);
    drive1(1, 0, 1, '0);
    wait_rdy(1, "t4_rdy1_a");
    repeat (2) step();
    drive1(0, 0, 0, '0);
    drive0(1, 0, 0, '0);
    step();
    check("t4_scrub_start", scrubbing, 1);
    drive0(0, 0, 0, '0);
    repeat (4) step();
    check("t4_idle_owner", owner, 0);
    check("t4_idle_scrub", scrubbing, 0);
    check("t4_idle_rdy", {req1_rdy, req0_rdy}, 0);
    drive0(1, 0, 0, '0);
    drive1(1, 0, 0, '0);
    step();
    check("t4a_rdy0", req0_rdy, 1);
    check("t4a_noscrub", scrubbing, 0);

    // 4b: owner=1 with last=1 -> domain 0 wins after a scrub
    drive0(0, 0, 0, '0);
    wait_rdy(1, "t4_rdy1_b");
    drive1(0, 0, 0, '0);
    step();
    check("t4b_idle_owner", owner, 1);
    check("t4b_idle_rdy", {req1_rdy, req0_rdy}, 0);
    drive0(1, 0, 0, '0);
    drive1(1, 0, 0, '0);
    step();
    check("t4b_scrub", scrubbing, 1);
    check("t4b_rdy1", req1_rdy, 0);
    wait_rdy(0, "t4b_rdy0");
    check("t4b_owner", owner, 0);

    // 5: fill the bank, then reset during the second scrub cycle
    drive1(0, 0, 0, '0);
    for (int a = 0; a < NREGS; a++) begin
      drive0(1, 1, 2'(a), 32'h1111_0000 + a);
      step();
    end
    drive0(0, 0, 0, '0);
    drive1(1, 0, 0, '0);
    step();
    check("t5_scrub1", scrubbing, 1);
    step();
    async_reset("t5");
    drive1(0, 0, 0, '0);
    drive0(1, 0, 0, '0);
    repeat (2) step();
    reset = 1'b1;
    step();
    for (int a = 0; a < NREGS; a++) begin
      req0_addr = 2'(a);
      step();
      check("t5_rd_val", resp_val, 1);
      check("t5_rd_zero", resp_rdata, 0);
    end

    // 6: final read at the forced yield returns in the first scrub cycle
    drive0(1, 1, 3, 32'hA5A5_0003);
    step();
    drive0(1, 0, 3, '0);
    drive1(1, 0, 3, '0);
    for (int i = 0; i < 20 && !scrubbing; i++) step();
    check("t6_scrub", scrubbing, 1);
    check("t6_resp_val", resp_val, 1);
    check("t6_rdata", resp_rdata, 32'hA5A5_0003);
    drive0(0, 0, 0, '0);
    wait_rdy(1, "t6_rdy1");
    step();
    check("t6_rd_val", resp_val, 1);
    check("t6_rd_zero", resp_rdata, 0);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom);
      drive1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rnd_rst");
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
